// File: rtl/counter_arbiter_pkg.sv
// Shared types and default parameters for the counter arbiter block.
package counter_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 16;
  localparam int unsigned DEFAULT_REQUESTERS   = 4;
  localparam int unsigned DEFAULT_LOCK_TIMEOUT = 8;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/counter_arbiter_if.sv
// Command/response bundle between the clients (master) and the counter arbiter (slave).
interface counter_arbiter_if
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned REQUESTERS = DEFAULT_REQUESTERS,
  localparam int unsigned ID_W      = $clog2(REQUESTERS)
);

  logic [REQUESTERS-1:0]       req_valid;
  logic [REQUESTERS-1:0]       req_lock;
  logic [2*REQUESTERS-1:0]     req_op;
  logic [WIDTH*REQUESTERS-1:0] req_value;
  logic [REQUESTERS-1:0]       req_ready;

  logic                        resp_valid;
  logic [ID_W-1:0]             resp_id;
  logic [WIDTH-1:0]            resp_value;

  modport master (
    output req_valid, req_lock, req_op, req_value,
    input  req_ready, resp_valid, resp_id, resp_value
  );

  modport slave (
    input  req_valid, req_lock, req_op, req_value,
    output req_ready, resp_valid, resp_id, resp_value
  );

endinterface

// File: rtl/counter_arbiter_round_robin_pick.sv
// Combinational round-robin picker: first set request at or after rr_i, scanning upward with wrap.
module round_robin_pick #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    rr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdW-1:0]    grant_idx_o
);

  logic [IdW-1:0] cand;
  logic           found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = rr_i;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        found         = 1'b1;
      end
      // Explicit wrap so non-power-of-two client counts stay in range.
      cand = (32'(cand) == NumReq - 1) ? '0 : cand + IdW'(1);
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared counter with round-robin arbitration, optional client lock with idle timeout,
// and one registered response per accepted command.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned REQUESTERS   = DEFAULT_REQUESTERS,
  parameter int unsigned LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT,
  localparam int unsigned ID_W        = $clog2(REQUESTERS)
) (
  input  logic             clock,
  input  logic             reset_,
  counter_arbiter_if.slave bus,
  output logic [WIDTH-1:0] counter,
  output logic             locked,
  output logic [ID_W-1:0]  owner
);

  localparam int unsigned TimerW = $clog2(LOCK_TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]      counter_q, counter_d;
  logic                  resp_valid_q;
  logic [ID_W-1:0]       resp_id_q;
  logic [WIDTH-1:0]      resp_value_q;

  logic [REQUESTERS-1:0] pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic [REQUESTERS-1:0] owner_onehot;
  logic [REQUESTERS-1:0] ready;
  logic [ID_W-1:0]       grant_idx;
  logic                  accept;

  op_t                   op_arr    [REQUESTERS];
  logic [WIDTH-1:0]      value_arr [REQUESTERS];

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (32'(id) == REQUESTERS - 1) ? '0 : id + ID_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < REQUESTERS; i++) begin
      op_arr[i]    = op_t'(bus.req_op[2*i +: 2]);
      value_arr[i] = bus.req_value[WIDTH*i +: WIDTH];
    end
  end

  round_robin_pick #(
    .NumReq (REQUESTERS)
  ) u_pick (
    .req_i       (bus.req_valid),
    .rr_i        (rr_q),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx)
  );

  // While locked only the owner may be granted; the picker is bypassed.
  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
    if (state_q == LOCKED) begin
      ready     = bus.req_valid & owner_onehot;
      grant_idx = owner_q;
    end else begin
      ready     = pick_grant;
      grant_idx = pick_idx;
    end
  end

  assign accept        = |ready;
  assign bus.req_ready = ready;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    counter_d = counter_q;

    if (accept) begin
      unique case (op_arr[grant_idx])
        OP_INC:  counter_d = counter_q + WIDTH'(1);
        OP_DEC:  counter_d = counter_q - WIDTH'(1);
        OP_LOAD: counter_d = value_arr[grant_idx];
        OP_READ: counter_d = counter_q;
        default: counter_d = counter_q;
      endcase
    end

    unique case (state_q)
      UNLOCKED: begin
        if (accept) begin
          rr_d    = next_id(grant_idx);
          timer_d = '0;
          if (bus.req_lock[grant_idx]) begin
            state_d = LOCKED;
            owner_d = grant_idx;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          timer_d = '0;
          if (!bus.req_lock[owner_q]) begin
            state_d = UNLOCKED;
            rr_d    = next_id(owner_q);
          end
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          // This idle cycle is the LOCK_TIMEOUT-th one: force release.
          state_d = UNLOCKED;
          rr_d    = next_id(owner_q);
          timer_d = '0;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= UNLOCKED;
      rr_q         <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      counter_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_value_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      counter_q    <= counter_d;
      resp_valid_q <= accept;
      if (accept) begin
        resp_id_q    <= grant_idx;
        resp_value_q <= counter_d;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_value = resp_value_q;
  assign counter        = counter_q;
  assign locked         = (state_q == LOCKED);
  assign owner          = owner_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and counter rules.
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic          clock  = 1'b0;
  logic          reset_ = 1'b1;
  logic [W-1:0]  counter;
  logic          locked;
  logic [1:0]    owner;

  counter_arbiter_if #(.WIDTH(W), .REQUESTERS(N)) bus ();

  counter_arbiter #(
    .WIDTH        (W),
    .REQUESTERS   (N),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clock   (clock),
    .reset_  (reset_),
    .bus     (bus),
    .counter (counter),
    .locked  (locked),
    .owner   (owner)
  );

  always #5 clock = ~clock;

  // Pending client commands (held until accepted)
  bit           c_valid [N];
  bit           c_lock  [N];
  logic [1:0]   c_op    [N];
  logic [W-1:0] c_value [N];

  // Behavioural model
  logic [W-1:0] m_counter;
  int           m_rr, m_owner, m_idle, m_resp_id;
  bit           m_locked, m_resp_valid;
  logic [W-1:0] m_resp_value;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    m_counter = '0; m_rr = 0; m_owner = 0; m_idle = 0; m_resp_id = 0;
    m_locked = 0; m_resp_valid = 0; m_resp_value = '0;
  endtask

  function automatic int model_grant();
    if (m_locked) return c_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (c_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_cmd(input int id, input logic [1:0] op, input logic [W-1:0] val,
                         input bit lk);
    c_valid[id] = 1'b1; c_op[id] = op; c_value[id] = val; c_lock[id] = lk;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = c_valid[i];
      bus.req_lock[i]          = c_lock[i];
      bus.req_op[2*i +: 2]     = c_op[i];
      bus.req_value[W*i +: W]  = c_value[i];
    end
  endtask

  // One clock: model applies the spec rules for this cycle, DUT sees the edge.
  task automatic tick();
    int g;
    drive();
    g = model_grant();
    if (g >= 0) begin
      case (c_op[g])
        2'b00:   m_counter = m_counter + 16'd1;
        2'b01:   m_counter = m_counter - 16'd1;
        2'b10:   m_counter = c_value[g];
        default: m_counter = m_counter;
      endcase
      m_resp_valid = 1; m_resp_id = g; m_resp_value = m_counter;
      m_idle = 0;
      if (!m_locked) begin
        m_rr = (g + 1) % N;
        if (c_lock[g]) begin m_locked = 1; m_owner = g; end
      end else if (!c_lock[g]) begin
        m_locked = 0; m_rr = (g + 1) % N;
      end
    end else begin
      m_resp_valid = 0;
      if (m_locked) begin
        m_idle++;
        if (m_idle == TO) begin m_locked = 0; m_rr = (m_owner + 1) % N; m_idle = 0; end
      end
    end
    @(negedge clock);
    if (g >= 0) c_valid[g] = 1'b0;
  endtask

  task automatic clear_cmds();
    for (int i = 0; i < N; i++) begin
      c_valid[i] = 0; c_lock[i] = 0; c_op[i] = 2'b11; c_value[i] = '0;
    end
  endtask

  task automatic test_reset();
    clear_cmds();
    model_reset();
    drive();
    #2 reset_ = 1'b0;
    #1;
    n_cmp += 6;
    if (counter !== 16'h0) begin n_err++; $display("FAIL reset_counter: got %h want 0000", counter); end
    if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    if (bus.resp_id !== 2'd0) begin n_err++; $display("FAIL reset_resp_id: got %0d want 0", bus.resp_id); end
    if (bus.resp_value !== 16'h0) begin n_err++; $display("FAIL reset_resp_value: got %h want 0000", bus.resp_value); end
    if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
  endtask

  task automatic test_inc_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_cmd(0, 2'b00, '0, 0);
      drive(); #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL inc_ready[%0d]: got %b want 0001", i, bus.req_ready); end
      tick();
      n_cmp += 3;
      if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL inc_resp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      if (bus.resp_id !== 2'd0) begin n_err++; $display("FAIL inc_resp_id[%0d]: got %0d want 0", i, bus.resp_id); end
      if (bus.resp_value !== 16'(i + 1)) begin n_err++; $display("FAIL inc_resp_value[%0d]: got %h want %h", i, bus.resp_value, 16'(i + 1)); end
    end
    tick();
    n_cmp += 3;
    if (counter !== 16'd3) begin n_err++; $display("FAIL inc_counter: got %h want 0003", counter); end
    if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL inc_resp_drop: got %b want 0", bus.resp_valid); end
    if (bus.resp_value !== 16'd3) begin n_err++; $display("FAIL inc_resp_hold: got %h want 0003", bus.resp_value); end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    set_cmd(3, 2'b11, '0, 0);
    tick();  // client 3 alone moves rr to 0
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < N; c++) if (!c_valid[c]) set_cmd(c, 2'b11, '0, 0);
      drive(); #1;
      n_cmp++;
      if (bus.req_ready !== 4'(1 << exp_seq[i])) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.req_ready, 4'(1 << exp_seq[i]));
      end
      tick();
      n_cmp += 2;
      if (bus.resp_id !== 2'(exp_seq[i])) begin n_err++; $display("FAIL rr_resp_id[%0d]: got %0d want %0d", i, bus.resp_id, exp_seq[i]); end
      if (bus.resp_value !== 16'd3) begin n_err++; $display("FAIL rr_resp_value[%0d]: got %h want 0003", i, bus.resp_value); end
    end
    clear_cmds();
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0]   ops  [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    logic [W-1:0] vals [4] = '{16'hFFFF, 16'h0, 16'h0, 16'h1234};
    logic [W-1:0] exps [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, ops[i], vals[i], 0);
      tick();
      n_cmp += 2;
      if (bus.resp_value !== exps[i]) begin n_err++; $display("FAIL wrap_resp[%0d]: got %h want %h", i, bus.resp_value, exps[i]); end
      if (counter !== exps[i]) begin n_err++; $display("FAIL wrap_counter[%0d]: got %h want %h", i, counter, exps[i]); end
    end
  endtask

  task automatic test_lock();
    set_cmd(1, 2'b11, '0, 0);
    tick();  // rr -> 2
    set_cmd(2, 2'b10, 16'h0010, 1);
    set_cmd(1, 2'b11, '0, 0);
    drive(); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_ready: got %b want 0100", bus.req_ready); end
    tick();
    n_cmp += 3;
    if (locked !== 1'b1) begin n_err++; $display("FAIL lock_locked: got %b want 1", locked); end
    if (owner !== 2'd2) begin n_err++; $display("FAIL lock_owner: got %0d want 2", owner); end
    if (bus.resp_value !== 16'h0010) begin n_err++; $display("FAIL lock_load: got %h want 0010", bus.resp_value); end
    for (int i = 0; i < 3; i++) begin
      drive(); #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL lock_stall[%0d]: got %b want 0000", i, bus.req_ready); end
      tick();
    end
    set_cmd(2, 2'b00, '0, 0);
    tick();
    n_cmp += 3;
    if (bus.resp_value !== 16'h0011) begin n_err++; $display("FAIL lock_inc: got %h want 0011", bus.resp_value); end
    if (bus.resp_id !== 2'd2) begin n_err++; $display("FAIL lock_inc_id: got %0d want 2", bus.resp_id); end
    if (locked !== 1'b0) begin n_err++; $display("FAIL lock_release: got %b want 0", locked); end
    drive(); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL lock_next_ready: got %b want 0010", bus.req_ready); end
    tick();
    n_cmp++;
    if (bus.resp_id !== 2'd1) begin n_err++; $display("FAIL lock_next_id: got %0d want 1", bus.resp_id); end
  endtask

  task automatic test_timeout();
    set_cmd(3, 2'b11, '0, 1);
    tick();
    n_cmp += 2;
    if (locked !== 1'b1) begin n_err++; $display("FAIL to_locked: got %b want 1", locked); end
    if (owner !== 2'd3) begin n_err++; $display("FAIL to_owner: got %0d want 3", owner); end
    set_cmd(1, 2'b11, '0, 0);
    for (int i = 1; i <= TO; i++) begin
      drive(); #1;
      n_cmp++;
      if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL to_stall[%0d]: got %b want 0000", i, bus.req_ready); end
      tick();
      n_cmp += 2;
      if (locked !== (i < TO)) begin n_err++; $display("FAIL to_locked[%0d]: got %b want %b", i, locked, (i < TO)); end
      if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL to_no_resp[%0d]: got %b want 0", i, bus.resp_valid); end
    end
    set_cmd(0, 2'b11, '0, 0);
    drive(); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL to_after_ready: got %b want 0001", bus.req_ready); end
    tick();
    clear_cmds();
    tick();
  endtask

  task automatic test_reset_mid();
    set_cmd(0, 2'b00, '0, 1);
    tick();
    n_cmp += 2;
    if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_resp: got %b want 1", bus.resp_valid); end
    if (locked !== 1'b1) begin n_err++; $display("FAIL mid_pre_locked: got %b want 1", locked); end
    reset_ = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_resp_valid: got %b want 0", bus.resp_valid); end
    if (locked !== 1'b0) begin n_err++; $display("FAIL mid_locked: got %b want 0", locked); end
    if (counter !== 16'h0) begin n_err++; $display("FAIL mid_counter: got %h want 0000", counter); end
    clear_cmds();
    model_reset();
    drive();
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    #1;
    set_cmd(1, 2'b00, '0, 0);
    drive(); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_after_ready: got %b want 0010", bus.req_ready); end
    tick();
    n_cmp += 2;
    if (bus.resp_id !== 2'd1) begin n_err++; $display("FAIL mid_after_id: got %0d want 1", bus.resp_id); end
    if (bus.resp_value !== 16'h0001) begin n_err++; $display("FAIL mid_after_value: got %h want 0001", bus.resp_value); end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!c_valid[i] && $urandom_range(0, 3) == 0) begin
          set_cmd(i, 2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 5) == 0));
        end
      end
      drive(); #1;
      er = exp_ready();
      n_cmp++;
      if (bus.req_ready !== er) begin n_err++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, bus.req_ready, er); end
      tick();
      n_cmp += 5;
      if (bus.resp_valid !== m_resp_valid) begin n_err++; $display("FAIL rand_resp_valid cyc %0d: got %b want %b", cyc, bus.resp_valid, m_resp_valid); end
      if (bus.resp_id !== 2'(m_resp_id)) begin n_err++; $display("FAIL rand_resp_id cyc %0d: got %0d want %0d", cyc, bus.resp_id, m_resp_id); end
      if (bus.resp_value !== m_resp_value) begin n_err++; $display("FAIL rand_resp_value cyc %0d: got %h want %h", cyc, bus.resp_value, m_resp_value); end
      if (counter !== m_counter) begin n_err++; $display("FAIL rand_counter cyc %0d: got %h want %h", cyc, counter, m_counter); end
      if (locked !== m_locked) begin n_err++; $display("FAIL rand_locked cyc %0d: got %b want %b", cyc, locked, m_locked); end
      if (m_locked) begin
        n_cmp++;
        if (owner !== 2'(m_owner)) begin n_err++; $display("FAIL rand_owner cyc %0d: got %0d want %0d", cyc, owner, m_owner); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc_back_to_back();
    test_round_robin();
    test_wrap();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one WIDTH-bit counter register between REQUESTERS independent clients. Each client issues increment, decrement, load and read commands over a valid/ready handshake. A round-robin arbiter with an optional lock grants one command per cycle, and every accepted command produces one registered response tagged with the requester id. The block owns the counter and sits between the input-event front ends and the display/output logic that consumes `counter`.

## Interface
- `WIDTH`, 16, counter and operand width
- `REQUESTERS`, 4, number of clients (≥2); `ID_W = $clog2(REQUESTERS)`
- `LOCK_TIMEOUT`, 8, idle cycles after which a held lock is force-released (≥1)

- `clock`  in  1  single clock, all state on posedge
- `reset_`  in  1  asynchronous, active-low reset
- `req_valid`  in  REQUESTERS  per-client command valid
- `req_lock`  in  REQUESTERS  per-client lock request, sampled with the command
- `req_op`  in  2*REQUESTERS  per-client opcode; client i uses bits [2i+1:2i]
- `req_value`  in  WIDTH*REQUESTERS  per-client LOAD operand; client i uses slice i
- `req_ready`  out  REQUESTERS  one-hot or zero grant, combinational
- `resp_valid`  out  1  response strobe, one cycle per accepted command
- `resp_id`  out  ID_W  requester index of the response
- `resp_value`  out  WIDTH  counter value after the command
- `counter`  out  WIDTH  current counter register
- `locked`  out  1  lock held
- `owner`  out  ID_W  lock holder; meaningful only while `locked`=1

## Operation
- Opcodes: 00 INC (+1), 01 DEC (−1), 10 LOAD (=req_value), 11 READ (no change). INC/DEC wrap modulo 2^WIDTH: all-ones +1 → 0, 0 −1 → all-ones.
- Accept on client i = `req_valid[i] & req_ready[i]`. At most one accept per cycle.
- A client holds valid, op, value and lock stable until accepted. Ready may depend combinationally on valid.
- FSM UNLOCKED:
  - Grant the first valid client at or after pointer `rr`, scanning upward with wrap.
  - On accept of client g: `rr` ← (g+1) mod REQUESTERS.
  - If `req_lock[g]`=1, go to LOCKED and set `owner` ← g.
- FSM LOCKED:
  - Only `owner` can receive ready; all other clients stall.
  - On an owner accept with `req_lock`=0: apply the command, go to UNLOCKED, `rr` ← owner+1.
  - On an owner accept with `req_lock`=1: stay LOCKED and clear the idle timer.
- Idle timer: counts LOCKED cycles in which `req_valid[owner]`=0. On the edge where it reaches LOCK_TIMEOUT: go to UNLOCKED, set `rr` ← owner+1, clear the timer. No command executes on that edge.
- A cycle with no valid clients leaves `rr` and the counter unchanged.

## Timing
- Command accepted in cycle N: `counter` updates at the end of N. `resp_valid`=1 in N+1 with `resp_id`=g and `resp_value`= new counter; READ returns the unchanged value.
- Back-to-back accepts give back-to-back responses. No backpressure on responses.
- `resp_valid` falls in the cycle after a cycle with no accept. `resp_id`/`resp_value` hold their last values.
- `locked`/`owner` change at the same edge as the accept or timeout that causes them.
- Reset values (async assert, sync-safe release): `counter`=0, `resp_valid`=0, `resp_id`=0, `resp_value`=0, `locked`=0, `owner`=0, `rr`=0, timer=0, state UNLOCKED.
- Reset asserted mid-lock or mid-response: all of the above return to reset values immediately. The pending response is dropped.

## Structure
- Package `counter_arbiter_pkg`:
  - `op_t` enum {OP_INC, OP_DEC, OP_LOAD, OP_READ}
  - `state_t` enum {UNLOCKED, LOCKED}
  - default WIDTH constant
- Sub-module `round_robin_pick`: combinational; inputs request vector and `rr`; outputs one-hot grant and its index.
- Top level holds the FSM, `rr`, the timer, the counter datapath (inc/dec/mux) and the response registers.

## Test plan
- After reset, client 0 INC ×3 back-to-back → responses (id 0, 1), (0, 2), (0, 3); `counter`=3.
- All four valid with READ, rr=0 → grants in order 0, 1, 2, 3, 0 on consecutive cycles; each `resp_id` matches its grant.
- `counter`=FFFF, INC → resp 0000; then DEC → resp FFFF; LOAD 1234 → resp 1234.
- Client 2 LOAD 0010 with lock=1, client 1 valid throughout → client 1 stalls. Client 2 INC with lock=0 → resp 0011, then client 1 is granted next cycle.
- Client 3 locks, then drops valid for LOCK_TIMEOUT=8 cycles → `locked` falls on the 8th idle edge with no response; rr=0 so client 0 is granted first.
- Assert `reset_` low during LOCKED with a response pending → `resp_valid`, `locked` and `counter` are 0 immediately; clean operation resumes after release.
